booth_mul_scheduler: RTL and testbench
======================================

// Module: booth_mul_scheduler
// PURPOSE
//  Round-robin scheduler that shares one booth_radix4_multiplier between REQ_N requesters.
//  Grants one request at a time and drives the multiplier control unit (begin_op) and inbus.
//  Feeds inbus with multiplicand, then multiplier, on consecutive cycles.
//  Returns the signed 16-bit product with the requester id on one valid/ready response port.
// PARAMETERS
//  REQ_N        2    number of requesters, 2..4
//  ID_W         1    width of rsp_id, must equal clog2(REQ_N)
//  TIMEOUT_CYC  64   WAIT-state cycle limit; used only when MUL_TIMEOUT_EN is defined
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         synchronous reset, active-high
//  req_valid    in   REQ_N     per-requester request strobe
//  req_a        in   REQ_N*8   signed multiplicand; requester i on bits [8i+7:8i]
//  req_b        in   REQ_N*8   signed multiplier; requester i on bits [8i+7:8i]
//  req_ready    out  REQ_N     one-hot accept pulse for the granted requester
//  rsp_valid    out  1         product available
//  rsp_ready    in   1         consumer accepts the product
//  rsp_id       out  ID_W      index of the requester that owns the product
//  rsp_data     out  16        signed product a*b
//  rsp_err      out  1         product invalid because of a timeout (always 0 without MUL_TIMEOUT_EN)
//  mul_begin    out  1         to the control unit's begin_op
//  mul_inbus    out  8         to the multiplier datapath's inbus
//  mul_end_op   in   1         from the control unit's end_op
//  mul_outbus   in   16        from the multiplier datapath's outbus
// BEHAVIOUR
//  Clock and reset
//   - One clock. Reset is synchronous and active-high.
//   - Reset forces: state=IDLE, rr_ptr=REQ_N-1.
//   - Reset forces all outputs to 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_begin, mul_inbus.
//   - Reset mid-operation abandons the job with no response.
//   - Top level ties the multiplier's rst_b to ~rst.
//  States: IDLE, SEND_M, SEND_Q, WAIT, RESP.
//  IDLE
//   - If any req_valid: grant g = first set bit searching upward from rr_ptr+1 (mod REQ_N).
//   - Same cycle: req_ready[g]=1 (combinational), latch req_a/req_b[g] into op_a/op_b.
//   - Same cycle: set rr_ptr=g, cur_id=g, go to SEND_M.
//   - req_ready is 0 in every other state.
//  SEND_M (1 cycle): mul_begin=1, mul_inbus=op_a; go to SEND_Q.
//  SEND_Q (1 cycle): mul_begin=0, mul_inbus=op_b; go to WAIT.
//  WAIT
//   - mul_inbus=0.
//   - On mul_end_op=1: capture mul_outbus into rsp_data (outbus is complete on the end_op cycle).
//   - Same cycle: rsp_id=cur_id, rsp_err=0, go to RESP.
//  RESP
//   - rsp_valid=1; rsp_id, rsp_data, rsp_err held stable until rsp_valid & rsp_ready.
//   - On handshake: go to IDLE. Next grant is no earlier than the following cycle.
//  Ignored inputs
//   - mul_end_op outside WAIT.
//   - req_valid changes after acceptance.
//   - req_valid of non-granted requesters; they wait and are not dropped.
//  Latency: accept cycle + 2 load cycles + multiplier run + end_op cycle, then RESP.
//  Arithmetic: two's complement. rsp_data = sign-extended op_a * op_b, range -16256..16384.
// CONFIGURATION
//  MUL_TIMEOUT_EN defined
//   - 8-bit wdog counter, cleared on entry to WAIT, incremented each WAIT cycle.
//   - When wdog == TIMEOUT_CYC-1 and mul_end_op=0: rsp_data=0, rsp_err=1, rsp_id=cur_id, go to RESP.
//   - The multiplier is not reset by this path; the integrator pulses rst on an error.
//  MUL_TIMEOUT_EN undefined
//   - No counter. WAIT lasts until mul_end_op. rsp_err is tied to 0.
// TESTING
//  - Single request: req0 a=7, b=-3 -> one req_ready[0] pulse.
//      mul_begin 1 cycle later with inbus=8'h07, then inbus=8'hFD.
//      Response: rsp_data=16'hFFEB, rsp_id=0.
//  - Corner operands: a=-128, b=-128 -> rsp_data=16'h4000. a=-128, b=127 -> rsp_data=16'hC080.
//  - Contention: after reset, req0 and req1 held high -> grants in order 0,1,0,1.
//      Each product returns with the matching rsp_id.
//  - Back-pressure: rsp_ready low for 5 cycles -> rsp_valid stays 1, rsp_data stable.
//      No req_ready pulse until the handshake completes.
//  - Reset mid-WAIT: rst=1 for 1 cycle -> state IDLE, all outputs 0, no response.
//      Next request completes normally.
//  - MUL_TIMEOUT_EN with mul_end_op stuck at 0 -> rsp_valid after TIMEOUT_CYC WAIT cycles.
//      Response: rsp_err=1, rsp_data=0.

Source files
------------

// File: rtl/booth_mul_scheduler_if.sv
// Request/response bundle for booth_mul_scheduler.
// master: requesters and response consumer. slave: the scheduler.
`timescale 1ns/1ps
interface booth_mul_scheduler_if #(
  parameter int REQ_N = 2,
  parameter int ID_W  = 1
);
  logic [REQ_N-1:0]   req_valid;
  logic [REQ_N*8-1:0] req_a;
  logic [REQ_N*8-1:0] req_b;
  logic [REQ_N-1:0]   req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/booth_mul_scheduler.sv
// booth_mul_scheduler: round-robin arbiter sharing one radix-4 Booth multiplier
// between REQ_N requesters. Loads multiplicand then multiplier on inbus over two
// cycles, waits for end_op and returns the signed product with the requester id.
// Optional feature macro: MUL_TIMEOUT_EN (WAIT-state watchdog, error response).
// The integrator ties the multiplier's rst_b to ~rst.
`timescale 1ns/1ps
module booth_mul_scheduler #(
  parameter int REQ_N       = 2,
  parameter int ID_W        = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_mul_scheduler_if.slave  bus,
  output logic                  mul_begin,
  output logic [7:0]            mul_inbus,
  input  logic                  mul_end_op,
  input  logic [15:0]           mul_outbus
);

  typedef enum logic [2:0] {IDLE, SEND_M, SEND_Q, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, cur_id_reg, rsp_id_reg;
  logic [7:0]      op_a_reg, op_b_reg;
  logic [15:0]     rsp_data_reg;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx, cand;
  logic            wait_timeout;
  logic            wait_done;
  logic [7:0]      req_a_arr [REQ_N];
  logic [7:0]      req_b_arr [REQ_N];

  // Split the flat operand buses into per-requester bytes and form the accept pulses
  for (genvar gi = 0; gi < REQ_N; gi++) begin : g_req
    assign req_a_arr[gi]     = bus.req_a[8*gi +: 8];
    assign req_b_arr[gi]     = bus.req_b[8*gi +: 8];
    assign bus.req_ready[gi] = !rst && (state_reg == IDLE) && grant_found &&
                               (grant_idx == ID_W'(gi));
  end

  // Round-robin pick: first valid requester searching upward from rr_ptr+1.
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = REQ_N; k >= 1; k--) begin
      cand = ID_W'((int'(rr_ptr_reg) + k) % REQ_N);
      if (bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign wait_done = (state_reg == WAIT) && (mul_end_op || wait_timeout);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and state-decoded outputs; outputs held low while rst is high
  always_comb begin
    state_next    = state_reg;
    mul_begin     = 1'b0;
    mul_inbus     = '0;
    bus.rsp_valid = 1'b0;
    case (state_reg)
      IDLE:   if (grant_found) state_next = SEND_M;
      SEND_M: begin
        mul_begin  = 1'b1;
        mul_inbus  = op_a_reg;
        state_next = SEND_Q;
      end
      SEND_Q: begin
        mul_inbus  = op_b_reg;
        state_next = WAIT;
      end
      WAIT:   if (mul_end_op || wait_timeout) state_next = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      mul_begin     = 1'b0;
      mul_inbus     = '0;
      bus.rsp_valid = 1'b0;
    end
  end

  // Operand latch on grant, response capture when the multiplier finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg   <= ID_W'(REQ_N - 1);
      cur_id_reg   <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      rsp_id_reg   <= '0;
      rsp_data_reg <= '0;
    end else begin
      if (state_reg == IDLE && grant_found) begin
        rr_ptr_reg <= grant_idx;
        cur_id_reg <= grant_idx;
        op_a_reg   <= req_a_arr[grant_idx];
        op_b_reg   <= req_b_arr[grant_idx];
      end
      if (wait_done) begin
        rsp_id_reg   <= cur_id_reg;
        rsp_data_reg <= mul_end_op ? mul_outbus : 16'h0000;
      end
    end
  end

  assign bus.rsp_id   = rsp_id_reg;
  assign bus.rsp_data = rsp_data_reg;

`ifdef MUL_TIMEOUT_EN
  logic [7:0] wdog_reg;
  logic       rsp_err_reg;

  assign wait_timeout = !mul_end_op && (wdog_reg == 8'(TIMEOUT_CYC - 1));

  // Watchdog counts WAIT cycles; held at zero elsewhere so it restarts on entry
  always_ff @(posedge clk) begin
    if (rst)                    wdog_reg <= '0;
    else if (state_reg != WAIT) wdog_reg <= '0;
    else                        wdog_reg <= wdog_reg + 8'd1;
  end

  // Error flag marks a response produced by the watchdog instead of end_op
  always_ff @(posedge clk) begin
    if (rst)            rsp_err_reg <= 1'b0;
    else if (wait_done) rsp_err_reg <= !mul_end_op;
  end

  assign bus.rsp_err = rsp_err_reg;
`else
  assign wait_timeout = 1'b0;
  assign bus.rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Bench for booth_mul_scheduler with a behavioural multiplier peripheral.
// Define MUL_TIMEOUT_EN for both files to also exercise the watchdog path.
`timescale 1ns/1ps
module tb_booth_mul_scheduler;
  localparam int REQ_N = 2;
  localparam int ID_W  = 1;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mul_scheduler_if #(.REQ_N(REQ_N), .ID_W(ID_W)) bus ();
  logic        mul_begin;
  logic [7:0]  mul_inbus;
  logic        mul_end_op = 1'b0;
  logic [15:0] mul_outbus = 16'h0;

  booth_mul_scheduler #(.REQ_N(REQ_N), .ID_W(ID_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_begin(mul_begin), .mul_inbus(mul_inbus),
    .mul_end_op(mul_end_op), .mul_outbus(mul_outbus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int mul_lat = 2;
  bit mul_stuck = 1'b0;

  // Multiplier stand-in: takes multiplicand with begin, multiplier next cycle,
  // pulses end_op after mul_lat cycles; random outbus and stray end_op otherwise.
  logic signed [7:0]  mm, mq;
  logic signed [15:0] mp;
  int phase = 0;
  int run_cnt = 0;
  always begin
    @(posedge clk); #1;
    if (rst) begin
      phase = 0; mul_end_op = 1'b0;
    end else begin
      case (phase)
        0: begin
          mul_end_op = ($urandom_range(0, 3) == 0);
          mul_outbus = 16'($urandom);
          if (mul_begin) begin mm = mul_inbus; mul_end_op = 1'b0; phase = 1; end
        end
        1: begin
          mq = mul_inbus; run_cnt = mul_lat; mul_end_op = 1'b0;
          mul_outbus = 16'($urandom); phase = 2;
        end
        2: begin
          if (mul_stuck) mul_end_op = 1'b0;
          else if (run_cnt == 0) begin
            mp = mm * mq; mul_end_op = 1'b1; mul_outbus = mp; phase = 3;
          end else begin
            run_cnt--; mul_end_op = 1'b0; mul_outbus = 16'($urandom);
          end
        end
        default: begin mul_end_op = 1'b0; mul_outbus = 16'($urandom); phase = 0; end
      endcase
    end
  end

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Drives one job from IDLE to response handshake; reports what came back.
  task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] d, output logic [ID_W-1:0] rid,
                         output logic e, output int cyc, output bit ok);
    int n;
    ok = 1'b0; d = '0; rid = '0; e = 1'b0; cyc = 0;
    bus.req_a[8*id +: 8] = a;
    bus.req_b[8*id +: 8] = b;
    bus.req_valid = '0;
    bus.req_valid[id] = 1'b1;
    n = 0;
    #1;
    while (!bus.req_ready[id] && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.req_ready[id]) begin bus.req_valid = '0; return; end
    @(negedge clk);
    bus.req_valid = '0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 300) begin @(negedge clk); cyc++; end
    if (!bus.rsp_valid) return;
    d = bus.rsp_data; rid = bus.rsp_id; e = bus.rsp_err; ok = 1'b1;
    $display("txn id=%0d a=%0d b=%0d -> rsp_id=%0d data=%h err=%0d lat=%0d",
             id, $signed(a), $signed(b), rid, d, e, cyc);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_valid = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    total_cnt++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); else pass_cnt++;
    total_cnt++; if ({bus.rsp_valid, bus.rsp_err, mul_begin} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {bus.rsp_valid, bus.rsp_err, mul_begin}); else pass_cnt++;
    total_cnt++; if ({bus.rsp_id, bus.rsp_data, mul_inbus} !== 25'h0) $display("FAIL reset_buses: got %h expected 0", {bus.rsp_id, bus.rsp_data, mul_inbus}); else pass_cnt++;
    bus.req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    bus.req_a[7:0] = 8'd7; bus.req_b[7:0] = 8'hFD; mul_lat = 2;
    bus.req_valid = 2'b01; #1;
    total_cnt++; if (bus.req_ready !== 2'b01) $display("FAIL single_ready: got %b expected 01", bus.req_ready); else pass_cnt++;
    @(negedge clk); bus.req_valid = 2'b00;
    total_cnt++; if ({mul_begin, mul_inbus} !== {1'b1, 8'h07}) $display("FAIL single_load_m: got %b/%h expected 1/07", mul_begin, mul_inbus); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 2'b00) $display("FAIL single_ready_pulse: got %b expected 00", bus.req_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({mul_begin, mul_inbus} !== {1'b0, 8'hFD}) $display("FAIL single_load_q: got %b/%h expected 0/fd", mul_begin, mul_inbus); else pass_cnt++;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b0, 16'hFFEB, 1'b0}) $display("FAIL single_rsp: got id=%0d data=%h err=%0d expected id=0 data=ffeb err=0", bus.rsp_id, bus.rsp_data, bus.rsp_err); else pass_cnt++;
    $display("txn id=0 a=7 b=-3 -> rsp_id=%0d data=%h err=%0d", bus.rsp_id, bus.rsp_data, bus.rsp_err);
    bus.rsp_ready = 1'b1; @(negedge clk); bus.rsp_ready = 1'b0; #1;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid); else pass_cnt++;
  endtask

  task automatic test_corners();
    logic [15:0] d; logic [ID_W-1:0] rid; logic e; int cyc; bit ok;
    run_one(0, 8'h80, 8'h80, d, rid, e, cyc, ok);
    total_cnt++; if (!ok || d !== 16'h4000 || rid !== 1'b0) $display("FAIL corner_neg_neg: got ok=%0d data=%h id=%0d expected ok=1 data=4000 id=0", ok, d, rid); else pass_cnt++;
    run_one(1, 8'h80, 8'h7F, d, rid, e, cyc, ok);
    total_cnt++; if (!ok || d !== 16'hC080 || rid !== 1'b1) $display("FAIL corner_neg_pos: got ok=%0d data=%h id=%0d expected ok=1 data=c080 id=1", ok, d, rid); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] d; logic [ID_W-1:0] rid; logic e; int cyc; bit ok;
    int id; logic [7:0] a, b;
    for (int i = 0; i < 10; i++) begin
      id = $urandom_range(0, REQ_N-1); a = 8'($urandom); b = 8'($urandom);
      mul_lat = $urandom_range(0, 6);
      run_one(id, a, b, d, rid, e, cyc, ok);
      total_cnt++; if (!ok || d !== ref_mul(a, b) || rid !== ID_W'(id) || e !== 1'b0) $display("FAIL random_%0d: got ok=%0d id=%0d data=%h err=%0d expected id=%0d data=%h err=0", i, ok, rid, d, e, id, ref_mul(a, b)); else pass_cnt++;
      total_cnt++; if (cyc !== mul_lat + 4) $display("FAIL random_lat_%0d: got %0d expected %0d", i, cyc, mul_lat + 4); else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    logic [7:0] ca[REQ_N], cb[REQ_N];
    int exp_id_q[$]; logic [15:0] exp_d_q[$];
    int order[4] = '{0, 1, 0, 1};
    int grants = 0, resps = 0, cyc = 0, pend = -1, gid, eid;
    logic [15:0] ed;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      ca[i] = 8'($urandom); cb[i] = 8'($urandom);
      bus.req_a[8*i +: 8] = ca[i]; bus.req_b[8*i +: 8] = cb[i];
    end
    mul_lat = 1; bus.rsp_ready = 1'b1; bus.req_valid = 2'b11;
    while (resps < 4 && cyc < 400) begin
      #1;
      if (bus.rsp_valid) begin
        total_cnt++; if (bus.req_ready !== 2'b00) $display("FAIL cont_no_grant_in_resp: got %b expected 00", bus.req_ready); else pass_cnt++;
        eid = exp_id_q.pop_front(); ed = exp_d_q.pop_front();
        total_cnt++; if (bus.rsp_id !== ID_W'(eid) || bus.rsp_data !== ed) $display("FAIL cont_rsp_%0d: got id=%0d data=%h expected id=%0d data=%h", resps, bus.rsp_id, bus.rsp_data, eid, ed); else pass_cnt++;
        $display("txn contention rsp #%0d id=%0d data=%h", resps, bus.rsp_id, bus.rsp_data);
        resps++;
      end
      if (bus.req_ready !== 2'b00 && grants < 4) begin
        gid = bus.req_ready[1] ? 1 : 0;
        total_cnt++; if (gid !== order[grants] || bus.req_ready !== (2'b01 << order[grants])) $display("FAIL cont_grant_%0d: got %b expected id %0d", grants, bus.req_ready, order[grants]); else pass_cnt++;
        exp_id_q.push_back(gid); exp_d_q.push_back(ref_mul(ca[gid], cb[gid]));
        pend = gid; grants++;
      end
      @(negedge clk); cyc++;
      if (pend >= 0) begin
        ca[pend] = 8'($urandom); cb[pend] = 8'($urandom);
        bus.req_a[8*pend +: 8] = ca[pend]; bus.req_b[8*pend +: 8] = cb[pend];
        if (grants == 4) bus.req_valid = 2'b00;
        pend = -1;
      end
    end
    total_cnt++; if (resps !== 4) $display("FAIL cont_budget: got %0d responses expected 4", resps); else pass_cnt++;
    bus.rsp_ready = 1'b0; bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [7:0] a1, b1, a0, b0; logic [15:0] exp1; int n;
    a1 = 8'($urandom); b1 = 8'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
    exp1 = ref_mul(a1, b1); mul_lat = 3;
    bus.req_a = {a1, a0}; bus.req_b = {b1, b0};
    bus.req_valid = 2'b10; n = 0; #1;
    while (bus.req_ready !== 2'b10 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); bus.req_valid = 2'b01;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if ({bus.rsp_valid, bus.req_ready} !== 3'b100 || bus.rsp_data !== exp1 || bus.rsp_id !== 1'b1) $display("FAIL bp_hold_%0d: got valid=%b ready=%b id=%0d data=%h expected valid=1 ready=00 id=1 data=%h", i, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_data, exp1); else pass_cnt++;
      @(negedge clk);
    end
    $display("txn back-pressure id=1 data=%h", bus.rsp_data);
    bus.rsp_ready = 1'b1; @(negedge clk); bus.rsp_ready = 1'b0; #1;
    total_cnt++; if (bus.req_ready !== 2'b01) $display("FAIL bp_next_grant: got %b expected 01", bus.req_ready); else pass_cnt++;
    @(negedge clk); bus.req_valid = 2'b00;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ref_mul(a0, b0) || bus.rsp_id !== 1'b0) $display("FAIL bp_second: got valid=%b id=%0d data=%h expected valid=1 id=0 data=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, ref_mul(a0, b0)); else pass_cnt++;
    $display("txn back-pressure id=0 data=%h", bus.rsp_data);
    bus.rsp_ready = 1'b1; @(negedge clk); bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] d; logic [ID_W-1:0] rid; logic e; int cyc; bit ok; bit seen;
    int n;
    mul_lat = 30;
    bus.req_a[7:0] = 8'd11; bus.req_b[7:0] = 8'd9; bus.req_valid = 2'b01; n = 0; #1;
    while (bus.req_ready !== 2'b01 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); bus.req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0; #1;
    total_cnt++; if ({bus.rsp_valid, bus.rsp_err, mul_begin, bus.req_ready} !== 5'b0) $display("FAIL rstw_flags: got %b expected 00000", {bus.rsp_valid, bus.rsp_err, mul_begin, bus.req_ready}); else pass_cnt++;
    total_cnt++; if ({bus.rsp_id, bus.rsp_data, mul_inbus} !== 25'h0) $display("FAIL rstw_buses: got %h expected 0", {bus.rsp_id, bus.rsp_data, mul_inbus}); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.rsp_valid) seen = 1'b1; end
    total_cnt++; if (seen !== 1'b0) $display("FAIL rstw_no_response: got %b expected 0", seen); else pass_cnt++;
    mul_lat = 1;
    run_one(0, 8'hF6, 8'd12, d, rid, e, cyc, ok);
    total_cnt++; if (!ok || d !== 16'hFF88 || rid !== 1'b0 || e !== 1'b0) $display("FAIL rstw_after: got ok=%0d data=%h id=%0d err=%0d expected data=ff88 id=0 err=0", ok, d, rid, e); else pass_cnt++;
  endtask

`ifdef MUL_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] d; logic [ID_W-1:0] rid; logic e; int cyc; bit ok;
    mul_stuck = 1'b1;
    run_one(1, 8'd5, 8'd5, d, rid, e, cyc, ok);
    total_cnt++; if (!ok || d !== 16'h0 || e !== 1'b1 || rid !== 1'b1) $display("FAIL timeout_rsp: got ok=%0d data=%h err=%0d id=%0d expected data=0000 err=1 id=1", ok, d, e, rid); else pass_cnt++;
    total_cnt++; if (cyc !== TO + 3) $display("FAIL timeout_lat: got %0d expected %0d", cyc, TO + 3); else pass_cnt++;
    rst = 1'b1; mul_stuck = 1'b0; @(negedge clk); rst = 1'b0; @(negedge clk);
    mul_lat = 2;
    run_one(0, 8'd5, 8'd5, d, rid, e, cyc, ok);
    total_cnt++; if (!ok || d !== 16'd25 || e !== 1'b0) $display("FAIL timeout_recover: got ok=%0d data=%h err=%0d expected data=0019 err=0", ok, d, e); else pass_cnt++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_corners();
    test_random();
    test_contention();
    test_back_pressure();
    test_reset_mid_wait();
`ifdef MUL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
